// File: rtl/userio_wheelkeys.sv
// rtl/userio_wheelkeys.sv - scroll-wheel counter to Amiga raw key press/release events
module userio_wheelkeys #(
    parameter logic [15:0] HOLD_TICKS = 16'd7000,
    parameter logic [15:0] GAP_TICKS  = 16'd7000,
    parameter int          PEND_MAX   = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk7_en,
    input  logic       wheel_en,
    input  logic [7:0] zcount,
    output logic [7:0] key_code,
    output logic       key_valid,
    input  logic       key_ack
);
    typedef enum logic [2:0] {IDLE, PRESS, HOLD, RELEASE, GAP} state_t;

    localparam logic signed [9:0] PMAX = 10'(PEND_MAX);

    state_t            state;
    logic [7:0]        zlast;
    logic signed [4:0] pending;
    logic [15:0]       timer;

    logic signed [7:0] delta;
    logic signed [1:0] take;
    logic signed [9:0] sum;
    logic signed [4:0] pending_next;
    logic              start;

    // Wheel notches and the notch consumed by a starting press fold into one saturating update.
    always_comb begin
        delta = zcount - zlast;
        start = (state == IDLE) && wheel_en && (pending != 5'sd0);
        take  = 2'sd0;
        if (start)
            take = pending[4] ? -2'sd1 : 2'sd1;
        sum = 10'(pending) + 10'(delta) - 10'(take);
        if (!wheel_en)
            pending_next = 5'sd0;
        else if (sum > PMAX)
            pending_next = 5'(PMAX);
        else if (sum < -PMAX)
            pending_next = 5'(-PMAX);
        else
            pending_next = sum[4:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            zlast     <= 8'h00;
            pending   <= 5'sd0;
            timer     <= 16'd0;
            key_code  <= 8'h00;
            key_valid <= 1'b0;
        end else if (clk7_en) begin
            zlast   <= zcount;
            pending <= pending_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        key_code  <= pending[4] ? 8'h7A : 8'h7B;
                        key_valid <= 1'b1;
                        state     <= PRESS;
                    end
                end
                PRESS: begin
                    if (key_ack) begin
                        key_valid <= 1'b0;
                        timer     <= HOLD_TICKS;
                        state     <= HOLD;
                    end
                end
                // key_code still carries the press code, so the release always matches it.
                HOLD: begin
                    if (timer == 16'd0) begin
                        key_code  <= key_code | 8'h80;
                        key_valid <= 1'b1;
                        state     <= RELEASE;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                RELEASE: begin
                    if (key_ack) begin
                        key_valid <= 1'b0;
                        timer     <= GAP_TICKS;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    if (timer == 16'd0)
                        state <= IDLE;
                    else
                        timer <= timer - 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
